// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and Gray/binary helpers for the async FIFO
//               pointer logic.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Default memory address width (DEPTH = 2**ADDRSIZE)
    localparam int unsigned C_ADDRSIZE_DEFAULT = 4;

    // Binary to reflected-Gray conversion
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Reflected-Gray to binary conversion (XOR prefix from the MSB down)
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_gray2bin.sv
`default_nettype none
// ============================================================================
// Module      : fifo_gray2bin
// Description : Combinational Gray-to-binary converter of parameterized
//               width, built as an XOR prefix chain from the MSB.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_gray2bin #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    // MSB passes straight through; every lower bit folds in the bit above
    assign o_bin[WIDTH-1] = i_gray[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bits
            assign o_bin[gi] = o_bin[gi+1] ^ i_gray[gi];
        end
    endgenerate

endmodule : fifo_gray2bin
`default_nettype wire

// File: rtl/fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_ctrl
// Description : Write-side pointer/flag controller of an asynchronous FIFO.
//               Keeps binary and Gray write pointers, registered full,
//               fill-level and almost-full flags, and an optional sticky
//               overflow flag.
// Config      : define FIFO_WOVERFLOW_EN to build the sticky woverflow
//               register; otherwise woverflow is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE     = C_ADDRSIZE_DEFAULT,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wclken,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                walmost_full,
    output logic                woverflow
);

    localparam logic [ADDRSIZE:0] C_AFULL = (ADDRSIZE + 1)'(AFULL_THRESH);

    logic [ADDRSIZE:0] wbin_q,  wbin_d;
    logic [ADDRSIZE:0] wptr_q,  wptr_d;
    logic              wfull_q, wfull_d;
    logic [ADDRSIZE:0] wlevel_q, wlevel_d;
    logic              wafull_q, wafull_d;
    logic [ADDRSIZE:0] w_rbin;
    logic [ADDRSIZE:0] w_full_cmp;

    // Synchronized read pointer back to binary for the level subtraction
    fifo_gray2bin #(
        .WIDTH (ADDRSIZE + 1)
    ) u_rptr_g2b (
        .i_gray (wq2_rptr),
        .o_bin  (w_rbin)
    );

    // Write pointer equals read pointer with its two MSBs inverted when the
    // FIFO holds exactly DEPTH entries (Gray-domain full test).
    assign w_full_cmp = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

    // Memory-side outputs come straight from the pointer register; a write
    // is accepted only when not full and not held in reset.
    assign waddr  = wbin_q[ADDRSIZE-1:0];
    assign wclken = winc & ~wfull_q & ~wrst;

    // Next-state pointers and flags derived from the accepted write
    always_comb begin
        wbin_d   = wbin_q + {{ADDRSIZE{1'b0}}, wclken};
        wptr_d   = (wbin_d >> 1) ^ wbin_d;
        wfull_d  = (wptr_d == w_full_cmp);
        wlevel_d = wbin_d - w_rbin;
        wafull_d = (wlevel_d >= C_AFULL);
    end

    // Pointer and flag registers with synchronous reset
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wfull_q  <= 1'b0;
            wlevel_q <= '0;
            wafull_q <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wfull_q  <= wfull_d;
            wlevel_q <= wlevel_d;
            wafull_q <= wafull_d;
        end
    end

    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign wlevel       = wlevel_q;
    assign walmost_full = wafull_q;

`ifdef FIFO_WOVERFLOW_EN
    logic woverflow_q, woverflow_d;

    // Overflow latches on any write attempt against a full FIFO
    always_comb begin
        woverflow_d = woverflow_q | (winc & wfull_q);
    end

    // Sticky overflow register, cleared only by reset
    always_ff @(posedge wclk) begin
        if (wrst) begin
            woverflow_q <= 1'b0;
        end else begin
            woverflow_q <= woverflow_d;
        end
    end

    assign woverflow = woverflow_q;
`else
    assign woverflow = 1'b0;
`endif

endmodule : fifo_wr_ctrl
`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_ctrl
// Description : Self-checking bench for fifo_wr_ctrl (ADDRSIZE=4,
//               AFULL_THRESH=12) against an occupancy-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_ctrl;

    localparam int DEPTH = 16;
    localparam int PMOD  = 32;
`ifdef FIFO_WOVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       winc = 1'b0;
    logic [4:0] wq2_rptr = '0;
    logic [3:0] waddr;
    logic       wclken;
    logic [4:0] wptr;
    logic       wfull;
    logic [4:0] wlevel;
    logic       walmost_full;
    logic       woverflow;

    int checks   = 0;
    int failures = 0;
    string phase = "init";

    // Reference model: write count and read count as plain integers mod 32
    int wcnt_m  = 0;
    int rcnt_m  = 0;
    int level_m = 0;
    bit full_m  = 0;
    bit afull_m = 0;
    bit ovf_m   = 0;

    fifo_wr_ctrl #(
        .ADDRSIZE     (4),
        .AFULL_THRESH (12)
    ) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .waddr        (waddr),
        .wclken       (wclken),
        .wptr         (wptr),
        .wfull        (wfull),
        .wlevel       (wlevel),
        .walmost_full (walmost_full),
        .woverflow    (woverflow)
    );

    always #5 wclk = ~wclk;

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, advance the
    // model at posedge, then check registered outputs just after the edge.
    task automatic cycle(input bit inc, input int rb, input bit rst);
        bit acc;
        bit full_old;
        @(negedge wclk);
        wrst     = rst;
        winc     = inc;
        rcnt_m   = rb % PMOD;
        wq2_rptr = gray5(rcnt_m);
        #1;
        acc = inc && !full_m && !rst;
        chk("wclken", 32'(wclken), 32'(acc));
        chk("waddr", 32'(waddr), 32'(wcnt_m % DEPTH));
        @(posedge wclk);
        full_old = full_m;
        if (rst) begin
            wcnt_m = 0; level_m = 0; full_m = 0; afull_m = 0; ovf_m = 0;
        end else begin
            wcnt_m  = (wcnt_m + int'(acc)) % PMOD;
            level_m = (wcnt_m - rcnt_m + PMOD) % PMOD;
            full_m  = (level_m == DEPTH);
            afull_m = (level_m >= 12);
            if (OVF_EN && inc && full_old) ovf_m = 1;
        end
        #1;
        chk("wptr", 32'(wptr), 32'(gray5(wcnt_m)));
        chk("wfull", 32'(wfull), 32'(full_m));
        chk("wlevel", 32'(wlevel), 32'(level_m));
        chk("walmost_full", 32'(walmost_full), 32'(afull_m));
        chk("woverflow", 32'(woverflow), 32'(ovf_m));
    endtask

    initial begin
        int rb;

        // Reset held two cycles with a write request pending
        phase = "reset";
        cycle(1, 0, 1);
        cycle(1, 0, 1);
        cycle(0, 0, 0);

        // Fill to full with the read pointer parked at zero
        phase = "fill";
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0);
        chk("fill_full", 32'(wfull), 32'd1);
        chk("fill_level", 32'(wlevel), 32'd16);

        // Write attempt against a full FIFO
        phase = "overflow";
        cycle(1, 0, 0);
        chk("ovf_level", 32'(wlevel), 32'd16);
        chk("ovf_flag", 32'(woverflow), 32'(OVF_EN));

        // Read pointer advances by one: same-cycle write dropped, next lands at 0
        phase = "drain";
        cycle(1, 1, 0);
        chk("drain_full", 32'(wfull), 32'd0);
        cycle(1, 1, 0);
        chk("drain_refull", 32'(wfull), 32'd1);

        // Long run with the reader two behind: pointers wrap, never full
        phase = "wrap";
        cycle(0, 0, 1);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        for (int i = 0; i < 40; i++) cycle(1, (wcnt_m + PMOD - 1) % PMOD, 0);
        chk("wrap_level", 32'(wlevel), 32'd2);
        chk("wrap_full", 32'(wfull), 32'd0);

        // Reset with nine entries outstanding
        phase = "midreset";
        cycle(0, 0, 1);
        for (int i = 0; i < 9; i++) cycle(1, 0, 0);
        chk("mid_level_pre", 32'(wlevel), 32'd9);
        cycle(1, 0, 1);
        chk("mid_level_post", 32'(wlevel), 32'd0);
        chk("mid_wptr_post", 32'(wptr), 32'd0);

        // Randomized traffic with occasional resets
        phase = "random";
        rb = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                rb = 0;
                cycle(1'($urandom_range(0, 1)), 0, 1);
            end else begin
                if ($urandom_range(0, 9) < 4 && rb != wcnt_m) rb = (rb + 1) % PMOD;
                cycle($urandom_range(0, 3) != 0, rb, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fifo_wr_ctrl
`default_nettype wire
